// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word per instruction from
// instruction memory, holds it for the decoders until the control unit advances.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  program_counter_function_select,
    input  logic        program_counter_input_select,
    input  logic        databus_program_counter_enable,
    input  logic [63:0] constant,
    input  logic [63:0] databus_in,
    input  logic        advance,
    output logic [63:0] imem_address,
    output logic        imem_request,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    output logic [31:0] instruction,
    output logic        instruction_valid,
    output logic [63:0] databus_out,
    output logic        databus_out_enable,
    output logic        misaligned
);

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    localparam logic [1:0] PC_HOLD   = 2'b00;
    localparam logic [1:0] PC_INC    = 2'b01;
    localparam logic [1:0] PC_LOAD   = 2'b10;
    localparam logic [1:0] PC_BRANCH = 2'b11;

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [XLEN-1:0]   r_pc;
    logic [ILEN-1:0]   r_instr;
    logic              r_valid;
    logic              r_req;
    logic              r_misaligned;

    logic              w_fetch_done;
    logic              w_take_advance;
    logic              w_req_next;
    logic              w_misalign_hit;
    logic [XLEN-1:0]   w_op;
    logic [XLEN-1:0]   w_next_pc;
    logic [XLEN-1:0]   w_link;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a fetch only completes while a request is actually out
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_FETCH: if (r_req && imem_ready) w_next_state = ST_HOLD;
            ST_HOLD:  if (advance)             w_next_state = ST_FETCH;
            default:                           w_next_state = ST_FETCH;
        endcase
    end

    // FSM control outputs
    always_comb begin
        w_fetch_done   = 1'b0;
        w_take_advance = 1'b0;
        w_req_next     = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_fetch_done = r_req & imem_ready;
                w_req_next   = ~(r_req & imem_ready);
            end
            ST_HOLD: begin
                w_take_advance = advance;
                w_req_next     = advance;
            end
            default: w_req_next = 1'b1;
        endcase
    end

    // PC update datapath, all arithmetic modulo 2^64
    always_comb begin
        w_op           = program_counter_input_select ? constant : databus_in;
        w_next_pc      = r_pc;
        w_misalign_hit = 1'b0;
        case (program_counter_function_select)
            PC_HOLD:   w_next_pc = r_pc;
            PC_INC:    w_next_pc = r_pc + XLEN'(4);
            PC_LOAD: begin
                w_next_pc      = {w_op[XLEN-1:2], 2'b00};
                w_misalign_hit = |w_op[1:0];
            end
            PC_BRANCH: w_next_pc = r_pc + {w_op[XLEN-3:0], 2'b00};
            default:   w_next_pc = r_pc;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc         <= RESET_PC;
            r_instr      <= '0;
            r_valid      <= 1'b0;
            r_req        <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_req <= w_req_next;
            if (w_fetch_done) begin
                r_instr <= imem_data;
                r_valid <= 1'b1;
            end
            if (w_take_advance) begin
                r_pc    <= w_next_pc;
                r_valid <= 1'b0;
                if (w_misalign_hit) r_misaligned <= 1'b1;
            end
        end
    end

    // Link value tracks the current (pre-update) PC
    assign w_link             = r_pc + XLEN'(4);
    assign databus_out        = w_link;
    assign databus_out_enable = databus_program_counter_enable & r_valid;
    assign imem_address       = r_pc;
    assign imem_request       = r_req;
    assign instruction        = r_instr;
    assign instruction_valid  = r_valid;
    assign misaligned         = r_misaligned;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  func;
    logic        sel;
    logic        dpce;
    logic [63:0] const_in;
    logic [63:0] db_in;
    logic        advance;
    logic [63:0] imem_address;
    logic        imem_request;
    logic        imem_ready;
    logic [31:0] imem_data;
    logic [31:0] instruction;
    logic        instruction_valid;
    logic [63:0] databus_out;
    logic        databus_out_enable;
    logic        misaligned;

    int total = 0;
    int bad   = 0;

    fetch_unit #(.RESET_PC(64'h0)) dut (
        .clock                           (clock),
        .reset                           (reset),
        .program_counter_function_select (func),
        .program_counter_input_select    (sel),
        .databus_program_counter_enable  (dpce),
        .constant                        (const_in),
        .databus_in                      (db_in),
        .advance                         (advance),
        .imem_address                    (imem_address),
        .imem_request                    (imem_request),
        .imem_ready                      (imem_ready),
        .imem_data                       (imem_data),
        .instruction                     (instruction),
        .instruction_valid               (instruction_valid),
        .databus_out                     (databus_out),
        .databus_out_enable              (databus_out_enable),
        .misaligned                      (misaligned)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Memory answers in the current cycle with the given word
    task automatic fetch_now(input logic [31:0] word);
        imem_data  = word;
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
    endtask

    task automatic do_advance(input logic [1:0] f, input logic s,
                              input logic [63:0] c, input logic [63:0] d);
        func     = f;
        sel      = s;
        const_in = c;
        db_in    = d;
        advance  = 1'b1;
        tick();
        advance  = 1'b0;
    endtask

    initial begin
        reset = 1'b1; func = 2'b00; sel = 1'b0; dpce = 1'b1;
        const_in = '0; db_in = '0; advance = 1'b0;
        imem_ready = 1'b0; imem_data = '0;

        // Asynchronous reset before any clock edge
        #2 reset = 1'b0;
        #1;
        check("rst_req",   64'(imem_request), 64'd0);
        check("rst_addr",  imem_address, 64'h0);
        check("rst_valid", 64'(instruction_valid), 64'd0);
        check("rst_instr", 64'(instruction), 64'h0);
        check("rst_mis",   64'(misaligned), 64'd0);
        check("rst_dboe",  64'(databus_out_enable), 64'd0);
        tick();
        check("rst_low_req", 64'(imem_request), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        dpce  = 1'b0;

        // Three wait cycles at address 0, then the word arrives
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wait_req",  64'(imem_request), 64'd1);
            check("wait_addr", imem_address, 64'h0);
        end
        fetch_now(32'h1400_0002);
        check("f0_instr", 64'(instruction), 64'h1400_0002);
        check("f0_valid", 64'(instruction_valid), 64'd1);
        check("f0_req",   64'(imem_request), 64'd0);

        // Ready in HOLD is ignored
        fetch_now(32'hDEAD_BEEF);
        check("hold_instr", 64'(instruction), 64'h1400_0002);
        check("hold_req",   64'(imem_request), 64'd0);
        check("link0",      databus_out, 64'h4);
        check("dboe_off",   64'(databus_out_enable), 64'd0);

        // Absolute load to 0x80, then advance during FETCH is ignored
        do_advance(2'b10, 1'b1, 64'h80, 64'h0);
        check("ld80_addr",  imem_address, 64'h80);
        check("ld80_req",   64'(imem_request), 64'd1);
        check("ld80_valid", 64'(instruction_valid), 64'd0);
        do_advance(2'b01, 1'b1, 64'h0, 64'h0);
        check("fetch_adv_addr", imem_address, 64'h80);
        check("fetch_adv_req",  64'(imem_request), 64'd1);
        fetch_now(32'h0000_0013);
        dpce = 1'b1;
        #1;
        check("link80",    databus_out, 64'h84);
        check("dboe80",    64'(databus_out_enable), 64'd1);
        dpce = 1'b0;

        // Negative PC-relative branch from 0x100
        do_advance(2'b10, 1'b1, 64'h100, 64'h0);
        fetch_now(32'h0000_0001);
        func = 2'b11; sel = 1'b1; const_in = 64'hFFFF_FFFF_FFFF_FFFE; advance = 1'b1;
        #1;
        check("link_pre_upd", databus_out, 64'h104);
        tick();
        advance = 1'b0;
        check("br_addr", imem_address, 64'hF8);
        check("br_req",  64'(imem_request), 64'd1);
        fetch_now(32'h0000_0002);

        // PC+4 wraps to zero, then hold refetches the same address
        do_advance(2'b10, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0);
        check("top_mis", 64'(misaligned), 64'd0);
        fetch_now(32'h0000_0003);
        check("link_wrap", databus_out, 64'h0);
        do_advance(2'b01, 1'b0, 64'h0, 64'h0);
        check("wrap_addr", imem_address, 64'h0);
        fetch_now(32'h0000_0004);
        do_advance(2'b00, 1'b0, 64'h0, 64'h0);
        check("refetch_addr",  imem_address, 64'h0);
        check("refetch_req",   64'(imem_request), 64'd1);
        check("refetch_valid", 64'(instruction_valid), 64'd0);
        fetch_now(32'h0000_0005);

        // Misaligned register-sourced absolute target; flag is sticky
        do_advance(2'b10, 1'b1, 64'h40, 64'h0);
        fetch_now(32'h0000_0006);
        do_advance(2'b10, 1'b0, 64'h999, 64'h203);
        check("mis_addr", imem_address, 64'h200);
        check("mis_set",  64'(misaligned), 64'd1);
        fetch_now(32'h0000_0007);
        do_advance(2'b01, 1'b0, 64'h0, 64'h0);
        check("mis_addr2",  imem_address, 64'h204);
        check("mis_sticky", 64'(misaligned), 64'd1);

        // Reset pulse between edges mid-fetch; late ready must be ignored
        #2 reset = 1'b0;
        #1;
        check("mid_rst_req",  64'(imem_request), 64'd0);
        check("mid_rst_addr", imem_address, 64'h0);
        check("mid_rst_mis",  64'(misaligned), 64'd0);
        #1 reset = 1'b1;
        fetch_now(32'hCAFE_F00D);
        check("late_valid", 64'(instruction_valid), 64'd0);
        check("late_instr", 64'(instruction), 64'h0);
        check("late_req",   64'(imem_request), 64'd1);
        fetch_now(32'h1400_0002);
        check("recov_valid", 64'(instruction_valid), 64'd1);
        check("recov_instr", 64'(instruction), 64'h1400_0002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, meaning the PC value loaded on reset.
REQ-002 SHALL have port clock, input, 1, system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port program_counter_function_select, input, 2, PC update: 00 hold, 01 PC+4, 10 absolute load, 11 PC-relative branch.
REQ-005 SHALL have port program_counter_input_select, input, 1, operand source: 1 selects constant, 0 selects databus_in.
REQ-006 SHALL have port databus_program_counter_enable, input, 1, drives the link value onto the databus.
REQ-007 SHALL have port constant, input, 64, sign-extended immediate from the decoder.
REQ-008 SHALL have port databus_in, input, 64, databus value used as the register-sourced target.
REQ-009 SHALL have port advance, input, 1, one-cycle pulse from the control unit marking the end of execution for the held instruction.
REQ-010 SHALL have port imem_address, output, 64, instruction memory address, equal to the PC.
REQ-011 SHALL have port imem_request, output, 1, fetch request.
REQ-012 SHALL have port imem_ready, input, 1, memory has imem_data valid this cycle.
REQ-013 SHALL have port imem_data, input, 32, fetched instruction word.
REQ-014 SHALL have port instruction, output, 32, registered instruction for the decoders.
REQ-015 SHALL have port instruction_valid, output, 1, instruction holds a fetched word.
REQ-016 SHALL have port databus_out, output, 64, link value, PC+4.
REQ-017 SHALL have port databus_out_enable, output, 1, databus_out is driving.
REQ-018 SHALL have port misaligned, output, 1, sticky flag set by an unaligned absolute target.

Function
REQ-019 SHALL implement a two-state FSM, FETCH and HOLD.
REQ-020 In FETCH, SHALL assert imem_request and hold imem_address at the PC until a cycle with imem_ready=1.
REQ-021 On the FETCH edge where imem_ready=1, SHALL register imem_data into instruction, set instruction_valid=1 and go to HOLD; fetch-to-valid latency is one edge after ready.
REQ-022 In HOLD, SHALL deassert imem_request, keep instruction stable, and ignore imem_ready.
REQ-023 On a HOLD edge with advance=1, SHALL update the PC per function_select, clear instruction_valid and go to FETCH; imem_request rises the next cycle with the new address.
REQ-024 advance asserted in FETCH SHALL be ignored, with no PC change and no state change.
REQ-025 Operand op SHALL be constant if input_select=1, else databus_in.
REQ-026 PC updates: 00 PC unchanged, meaning the same address is refetched; 01 PC+4; 10 PC<=op with op[1:0] forced to 00; 11 PC<=PC+(op<<2).
REQ-027 All PC arithmetic SHALL be 64-bit modulo 2^64; wrap-around carries SHALL be discarded silently; bits shifted out of op<<2 SHALL be discarded.
REQ-028 With function_select=10 and op[1:0]!=00 on an advance edge, SHALL set misaligned=1; misaligned SHALL clear only on reset.
REQ-029 databus_out SHALL combinationally equal PC+4 of the current PC at all times.
REQ-030 databus_out_enable SHALL equal databus_program_counter_enable AND instruction_valid.
REQ-031 The link value on the databus SHALL always reflect the pre-update PC, including in the cycle advance is sampled.

Reset
REQ-032 On reset low, SHALL immediately, without waiting for a clock, set PC=RESET_PC, state=FETCH, instruction=32'h0, instruction_valid=0, misaligned=0, imem_request=0 and databus_out_enable=0.
REQ-033 While reset is low, imem_request SHALL stay 0.
REQ-034 From the first rising edge after reset release, SHALL assert imem_request with imem_address=RESET_PC.
REQ-035 Reset asserted mid-fetch or in HOLD SHALL abandon the transaction, and a late imem_ready SHALL be ignored.

Verification
REQ-036 Bench SHALL cover: reset release, then imem_ready after 3 wait cycles with data 32'h14000002 -> address 0 held 3 cycles; next edge instruction=32'h14000002, valid=1, request=0.
REQ-037 Bench SHALL cover: PC=0x100, func=11, sel=1, constant=64'hFFFF_FFFF_FFFF_FFFE, advance -> PC=0xF8, request high next cycle.
REQ-038 Bench SHALL cover: PC=0x40, func=10, sel=0, databus_in=0x203, advance -> PC=0x200, misaligned=1, which persists until reset.
REQ-039 Bench SHALL cover: PC=64'hFFFF_FFFF_FFFF_FFFC, func=01, advance -> PC=0; then func=00, advance -> refetch at address 0.
REQ-040 Bench SHALL cover: HOLD, PC=0x80, databus_program_counter_enable=1 -> databus_out=0x84, enable=1; advance pulsed during FETCH -> PC unchanged.
REQ-041 Bench SHALL cover: reset pulsed low mid-fetch between clock edges -> request drops immediately, PC=RESET_PC, and the subsequent imem_ready does not set valid.
